// File: rtl/seq_divu_if.sv
// rtl/seq_divu_if.sv - launch/result bundle between ALU control and the sequential unsigned divider
interface seq_divu_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic [WIDTH-1:0]   dataA;
    logic [WIDTH-1:0]   dataB;
    logic               busy;
    logic               done;
    logic               divZero;
    logic [2*WIDTH-1:0] dataOut;

    modport master (
        output start, dataA, dataB,
        input  busy, done, divZero, dataOut
    );

    modport slave (
        input  start, dataA, dataB,
        output busy, done, divZero, dataOut
    );
endinterface

// File: rtl/seq_divu.sv
// rtl/seq_divu.sv - restoring unsigned divider, one quotient bit per cycle, result {rem, quo}
// Optional macro DIVU_ZERO_FAST_EN: zero divisor completes in one cycle and raises divZero.
module seq_divu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic      clk,
    input  logic      reset,
    seq_divu_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;
    logic [2*WIDTH-1:0] data_out_q, data_out_d;

    // The dividend register doubles as the quotient: bits leave at the MSB, quotient bits enter at the LSB.
    logic [WIDTH:0]     rem_shift;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;

    assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
    assign q_bit     = (rem_shift >= {1'b0, dvs_q});
    assign rem_next  = q_bit ? WIDTH'(rem_shift - {1'b0, dvs_q}) : rem_shift[WIDTH-1:0];
    assign quo_next  = {dvd_q[WIDTH-2:0], q_bit};

    always_comb begin
        state_d    = state_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        data_out_d = data_out_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    dvd_d      = bus.dataA;
                    dvs_d      = bus.dataB;
                    rem_d      = '0;
                    cnt_d      = '0;
                    div_zero_d = 1'b0;
`ifdef DIVU_ZERO_FAST_EN
                    if (bus.dataB == '0) begin
                        state_d    = S_DONE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        div_zero_d = 1'b1;
                        data_out_d = {bus.dataA, {WIDTH{1'b1}}};
                    end else begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                    end
`else
                    state_d = S_RUN;
                    busy_d  = 1'b1;
`endif
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_RUN: begin
                rem_d = rem_next;
                dvd_d = quo_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d    = S_DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    data_out_d = {rem_next, quo_next};
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            data_out_q <= data_out_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.divZero = div_zero_q;
    assign bus.dataOut = data_out_q;
endmodule

// File: tb/tb_seq_divu.sv
// tb/tb_seq_divu.sv - self-checking bench for seq_divu: vector table, random vs model, corner sequences
module tb_seq_divu;
    localparam int W = 32;
`ifdef DIVU_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;

    seq_divu_if #(.WIDTH(W)) bus ();
    seq_divu #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [2*W-1:0] ref_div(logic [W-1:0] a, logic [W-1:0] b);
        if (b == 0) return {a, {W{1'b1}}};
        return {a % b, a / b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [2*W-1:0] got, logic [2*W-1:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic launch(logic [W-1:0] a, logic [W-1:0] b);
        bus.dataA = a;
        bus.dataB = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_check(string name, logic [W-1:0] a, logic [W-1:0] b, logic [2*W-1:0] exp);
        int lat;
        bit zero_fast;
        zero_fast = FAST && (b == 0);
        launch(a, b);
        if (!zero_fast) chk({name, ".busy"}, 64'(bus.busy), 64'd1);
        wait_done(lat);
        chk({name, ".data"}, bus.dataOut, exp);
        chk({name, ".lat"}, 64'(lat), zero_fast ? 64'd0 : 64'(W));
        chk({name, ".dz"}, 64'(bus.divZero), 64'(zero_fast));
    endtask

    initial begin
        int lat;
        int dones;
        logic [W-1:0] ra, rb;

        tbl[0] = '{32'd100,        32'd7,          {32'd2,  32'd14}};
        tbl[1] = '{32'hFFFFFFFF,   32'd1,          {32'd0,  32'hFFFFFFFF}};
        tbl[2] = '{32'd5,          32'd9,          {32'd5,  32'd0}};
        tbl[3] = '{32'd42,         32'd0,          {32'd42, 32'hFFFFFFFF}};
        tbl[4] = '{32'd77,         32'd8,          {32'd5,  32'd9}};
        tbl[5] = '{32'd1000,       32'd10,         {32'd0,  32'd100}};
        tbl[6] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   {32'd0,  32'd1}};
        tbl[7] = '{32'd0,          32'd5,          {32'd0,  32'd0}};
        tbl[8] = '{32'h80000000,   32'd3,          {32'd2,  32'h2AAAAAAA}};

        // reset held low with start asserted: nothing may launch
        reset     = 1'b0;
        bus.start = 1'b1;
        bus.dataA = 32'd5;
        bus.dataB = 32'd1;
        tick();
        tick();
        chk("rst.busy", 64'(bus.busy), 64'd0);
        chk("rst.done", 64'(bus.done), 64'd0);
        chk("rst.data", bus.dataOut, 64'd0);
        chk("rst.dz", 64'(bus.divZero), 64'd0);
        bus.start = 1'b0;
        reset     = 1'b1;
        tick();
        chk("rst.idle", 64'(bus.busy), 64'd0);

        for (int i = 0; i < 9; i++) begin
            run_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].exp);
            tick();
            chk($sformatf("tbl%0d.pulse", i), 64'(bus.done), 64'd0);
        end

        // back-to-back: second start asserted during the DONE cycle
        run_check("b2b0", 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF});
        run_check("b2b1", 32'd5, 32'd9, {32'd5, 32'd0});
        tick();

        // start while busy is ignored; dataOut holds the previous result meanwhile
        launch(32'd1000, 32'd10);
        repeat (4) tick();
        chk("ign.hold", bus.dataOut, {32'd5, 32'd0});
        bus.dataA = 32'd9;
        bus.dataB = 32'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("ign.busy", 64'(bus.busy), 64'd1);
        wait_done(lat);
        chk("ign.data", bus.dataOut, {32'd0, 32'd100});
        chk("ign.lat", 64'(lat + 5), 64'(W));
        tick();

        // reset mid-division aborts without a done pulse
        launch(32'd1234, 32'd7);
        repeat (9) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort.busy", 64'(bus.busy), 64'd0);
        chk("abort.data", bus.dataOut, 64'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) dones++;
            tick();
        end
        chk("abort.nodone", 64'(dones), 64'd0);
        run_check("abort.next", 32'd77, 32'd8, {32'd5, 32'd9});
        tick();

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            if (i % 5 == 1) rb = rb >> $urandom_range(0, 31);
            run_check($sformatf("rnd%0d", i), ra, rb, ref_div(ra, rb));
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
